control_sequencer: RTL and testbench

- Moore-style control unit that drives every control strobe of the Datapath block.
- Sequences instruction fetch (T0–T2) and the execute steps for ALU register, ALU immediate, ldi, unary, mul/div, nop and halt instructions.
- Takes the instruction opcode from the IR contents the datapath exports, and replaces the hand-driven step sequences used in datapath-level benches.
- Each control step lasts exactly one clock.

---
 rtl/control_sequencer_if.sv | 43 ++++
 rtl/control_sequencer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_if
// Description : Control bundle between the control sequencer and the
//               datapath: IR/Stop back from the datapath, every control
//               strobe plus Run out to it.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_sequencer_if;
    logic [31:0] IR;
    logic        Stop;
    logic        Run;
    logic        PCout, PCin, IncPC, MARin;
    logic        MDRin, MDRout, MDMuxread, RAMread;
    logic        IRin, Yin, CSEout;
    logic        Zlowin, Zlowout, Zhighin, Zhighout;
    logic        HIin, LOin;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL;
    logic        MUL, DIV, NEG, NOT;
    logic        RAMwrite, CONin, InPortout, OutPortin, HIout, LOout;

    // Sequencer side
    modport master (
        input  IR, Stop,
        output Run, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread,
               RAMread, IRin, Yin, CSEout, Zlowin, Zlowout, Zhighin,
               Zhighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout, BAout,
               ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG,
               NOT, RAMwrite, CONin, InPortout, OutPortin, HIout, LOout
    );

    // Datapath side
    modport slave (
        output IR, Stop,
        input  Run, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread,
               RAMread, IRin, Yin, CSEout, Zlowin, Zlowout, Zhighin,
               Zhighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout, BAout,
               ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG,
               NOT, RAMwrite, CONin, InPortout, OutPortin, HIout, LOout
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Moore control unit for the datapath. Fetches (T0-T2), then
//               runs the execute steps for ALU reg/imm, ldi, unary, mul/div,
//               nop and halt. All strobes are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int OP_MSB   = 31,
    parameter int OP_WIDTH = 5
) (
    input  wire logic           clock,
    input  wire logic           clear,
    control_sequencer_if.master bus
);

    localparam logic [3:0] ST_RESET = 4'd0;
    localparam logic [3:0] ST_T0    = 4'd1;
    localparam logic [3:0] ST_T1    = 4'd2;
    localparam logic [3:0] ST_T2    = 4'd3;
    localparam logic [3:0] ST_T3    = 4'd4;
    localparam logic [3:0] ST_T4    = 4'd5;
    localparam logic [3:0] ST_T5    = 4'd6;
    localparam logic [3:0] ST_T6    = 4'd7;
    localparam logic [3:0] ST_HALT  = 4'd8;

    localparam logic [OP_WIDTH-1:0] OPC_LDI  = OP_WIDTH'(5'b00001);
    localparam logic [OP_WIDTH-1:0] OPC_ADD  = OP_WIDTH'(5'b00011);
    localparam logic [OP_WIDTH-1:0] OPC_SUB  = OP_WIDTH'(5'b00100);
    localparam logic [OP_WIDTH-1:0] OPC_AND  = OP_WIDTH'(5'b00101);
    localparam logic [OP_WIDTH-1:0] OPC_OR   = OP_WIDTH'(5'b00110);
    localparam logic [OP_WIDTH-1:0] OPC_ROR  = OP_WIDTH'(5'b00111);
    localparam logic [OP_WIDTH-1:0] OPC_ROL  = OP_WIDTH'(5'b01000);
    localparam logic [OP_WIDTH-1:0] OPC_SHR  = OP_WIDTH'(5'b01001);
    localparam logic [OP_WIDTH-1:0] OPC_SHRA = OP_WIDTH'(5'b01010);
    localparam logic [OP_WIDTH-1:0] OPC_SHL  = OP_WIDTH'(5'b01011);
    localparam logic [OP_WIDTH-1:0] OPC_ADDI = OP_WIDTH'(5'b01100);
    localparam logic [OP_WIDTH-1:0] OPC_ANDI = OP_WIDTH'(5'b01101);
    localparam logic [OP_WIDTH-1:0] OPC_ORI  = OP_WIDTH'(5'b01110);
    localparam logic [OP_WIDTH-1:0] OPC_DIV  = OP_WIDTH'(5'b01111);
    localparam logic [OP_WIDTH-1:0] OPC_MUL  = OP_WIDTH'(5'b10000);
    localparam logic [OP_WIDTH-1:0] OPC_NEG  = OP_WIDTH'(5'b10001);
    localparam logic [OP_WIDTH-1:0] OPC_NOT  = OP_WIDTH'(5'b10010);
    localparam logic [OP_WIDTH-1:0] OPC_HALT = OP_WIDTH'(5'b11011);

    // Instruction classes; anything unrecognised (nop included) is CLS_NONE
    localparam logic [2:0] CLS_NONE   = 3'd0;
    localparam logic [2:0] CLS_REG    = 3'd1;
    localparam logic [2:0] CLS_IMM    = 3'd2;
    localparam logic [2:0] CLS_LDI    = 3'd3;
    localparam logic [2:0] CLS_UNARY  = 3'd4;
    localparam logic [2:0] CLS_MULDIV = 3'd5;
    localparam logic [2:0] CLS_HALT   = 3'd6;

    typedef struct packed {
        logic Run;
        logic PCout, PCin, IncPC, MARin;
        logic MDRin, MDRout, MDMuxread, RAMread;
        logic IRin, Yin, CSEout;
        logic Zlowin, Zlowout, Zhighin, Zhighout;
        logic HIin, LOin;
        logic Gra, Grb, Grc, Rin, Rout, BAout;
        logic ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL;
        logic MUL, DIV, NEG, NOT;
    } ctrl_t;

    function automatic logic [2:0] op_class(input logic [OP_WIDTH-1:0] op);
        case (op)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR,
            OPC_ROL, OPC_SHR, OPC_SHRA, OPC_SHL:   op_class = CLS_REG;
            OPC_ADDI, OPC_ANDI, OPC_ORI:           op_class = CLS_IMM;
            OPC_LDI:                               op_class = CLS_LDI;
            OPC_NEG, OPC_NOT:                      op_class = CLS_UNARY;
            OPC_MUL, OPC_DIV:                      op_class = CLS_MULDIV;
            OPC_HALT:                              op_class = CLS_HALT;
            default:                               op_class = CLS_NONE;
        endcase
    endfunction

    // Raise the single ALU select belonging to an opcode (ldi adds)
    function automatic ctrl_t with_op(input ctrl_t c, input logic [OP_WIDTH-1:0] op);
        ctrl_t r;
        r = c;
        case (op)
            OPC_ADD, OPC_ADDI, OPC_LDI: r.ADD  = 1'b1;
            OPC_SUB:                    r.SUB  = 1'b1;
            OPC_AND, OPC_ANDI:          r.AND  = 1'b1;
            OPC_OR, OPC_ORI:            r.OR   = 1'b1;
            OPC_ROR:                    r.ROR  = 1'b1;
            OPC_ROL:                    r.ROL  = 1'b1;
            OPC_SHR:                    r.SHR  = 1'b1;
            OPC_SHRA:                   r.SHRA = 1'b1;
            OPC_SHL:                    r.SHL  = 1'b1;
            OPC_MUL:                    r.MUL  = 1'b1;
            OPC_DIV:                    r.DIV  = 1'b1;
            OPC_NEG:                    r.NEG  = 1'b1;
            OPC_NOT:                    r.NOT  = 1'b1;
            default:                    r      = c;
        endcase
        return r;
    endfunction

    logic [3:0]          r_state;
    logic [OP_WIDTH-1:0] r_opcode;
    ctrl_t               r_ctrl;

    logic [3:0]          w_next_state;
    logic [OP_WIDTH-1:0] w_cur_op;
    logic [2:0]          w_cls;
    ctrl_t               w_ctrl;
    logic                w_unused_ir;

    // Only the opcode field of IR is decoded here
    assign w_unused_ir = ^bus.IR;

    // Next-state selection; the opcode is taken live from IR while in T2
    always_comb begin
        w_cur_op     = (r_state == ST_T2) ? bus.IR[OP_MSB -: OP_WIDTH] : r_opcode;
        w_cls        = op_class(w_cur_op);
        w_next_state = r_state;
        case (r_state)
            ST_RESET: w_next_state = ST_T0;
            ST_T0:    w_next_state = ST_T1;
            ST_T1:    w_next_state = ST_T2;
            ST_T2: begin
                if (w_cls == CLS_HALT)      w_next_state = ST_HALT;
                else if (w_cls == CLS_NONE) w_next_state = ST_T0;
                else                        w_next_state = ST_T3;
            end
            ST_T3:    w_next_state = ST_T4;
            ST_T4:    w_next_state = (w_cls == CLS_UNARY) ? ST_T0 : ST_T5;
            ST_T5:    w_next_state = (w_cls == CLS_MULDIV) ? ST_T6 : ST_T0;
            ST_T6:    w_next_state = ST_T0;
            ST_HALT:  w_next_state = ST_HALT;
            default:  w_next_state = ST_RESET;
        endcase
        // A stop request is only honoured on an instruction boundary
        if (w_next_state == ST_T0 && bus.Stop)
            w_next_state = ST_HALT;
        if (clear)
            w_next_state = ST_RESET;
    end

    // Strobes for the state being entered, so they register alongside it
    always_comb begin
        w_ctrl     = '0;
        w_ctrl.Run = (w_next_state >= ST_T0) && (w_next_state <= ST_T6);
        case (w_next_state)
            ST_T0: begin
                w_ctrl.PCout = 1'b1; w_ctrl.MARin = 1'b1;
                w_ctrl.IncPC = 1'b1; w_ctrl.Zlowin = 1'b1;
            end
            ST_T1: begin
                w_ctrl.Zlowout = 1'b1; w_ctrl.PCin  = 1'b1; w_ctrl.MDMuxread = 1'b1;
                w_ctrl.RAMread = 1'b1; w_ctrl.MDRin = 1'b1;
            end
            ST_T2: begin
                w_ctrl.MDRout = 1'b1; w_ctrl.IRin = 1'b1;
            end
            ST_T3: begin
                case (w_cls)
                    CLS_REG, CLS_IMM: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Yin = 1'b1;
                    end
                    CLS_LDI: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.BAout = 1'b1; w_ctrl.Yin = 1'b1;
                    end
                    CLS_UNARY: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Zlowin = 1'b1;
                        w_ctrl = with_op(w_ctrl, w_cur_op);
                    end
                    CLS_MULDIV: begin
                        w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Yin = 1'b1;
                    end
                    default: w_ctrl.Run = 1'b1;
                endcase
            end
            ST_T4: begin
                case (w_cls)
                    CLS_REG: begin
                        w_ctrl.Grc = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Zlowin = 1'b1;
                        w_ctrl = with_op(w_ctrl, w_cur_op);
                    end
                    CLS_IMM, CLS_LDI: begin
                        w_ctrl.CSEout = 1'b1; w_ctrl.Zlowin = 1'b1;
                        w_ctrl = with_op(w_ctrl, w_cur_op);
                    end
                    CLS_UNARY: begin
                        w_ctrl.Zlowout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                    end
                    CLS_MULDIV: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1;
                        w_ctrl.Zlowin = 1'b1; w_ctrl.Zhighin = 1'b1;
                        w_ctrl = with_op(w_ctrl, w_cur_op);
                    end
                    default: w_ctrl.Run = 1'b1;
                endcase
            end
            ST_T5: begin
                if (w_cls == CLS_MULDIV) begin
                    w_ctrl.Zlowout = 1'b1; w_ctrl.LOin = 1'b1;
                end else begin
                    w_ctrl.Zlowout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                end
            end
            ST_T6: begin
                w_ctrl.Zhighout = 1'b1; w_ctrl.HIin = 1'b1;
            end
            default: w_ctrl.Run = 1'b0;
        endcase
    end

    // State, latched opcode and registered strobes
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state  <= ST_RESET;
            r_opcode <= '0;
            r_ctrl   <= '0;
        end else begin
            r_state  <= w_next_state;
            r_opcode <= w_cur_op;
            r_ctrl   <= w_ctrl;
        end
    end

    assign bus.Run       = r_ctrl.Run;
    assign bus.PCout     = r_ctrl.PCout;
    assign bus.PCin      = r_ctrl.PCin;
    assign bus.IncPC     = r_ctrl.IncPC;
    assign bus.MARin     = r_ctrl.MARin;
    assign bus.MDRin     = r_ctrl.MDRin;
    assign bus.MDRout    = r_ctrl.MDRout;
    assign bus.MDMuxread = r_ctrl.MDMuxread;
    assign bus.RAMread   = r_ctrl.RAMread;
    assign bus.IRin      = r_ctrl.IRin;
    assign bus.Yin       = r_ctrl.Yin;
    assign bus.CSEout    = r_ctrl.CSEout;
    assign bus.Zlowin    = r_ctrl.Zlowin;
    assign bus.Zlowout   = r_ctrl.Zlowout;
    assign bus.Zhighin   = r_ctrl.Zhighin;
    assign bus.Zhighout  = r_ctrl.Zhighout;
    assign bus.HIin      = r_ctrl.HIin;
    assign bus.LOin      = r_ctrl.LOin;
    assign bus.Gra       = r_ctrl.Gra;
    assign bus.Grb       = r_ctrl.Grb;
    assign bus.Grc       = r_ctrl.Grc;
    assign bus.Rin       = r_ctrl.Rin;
    assign bus.Rout      = r_ctrl.Rout;
    assign bus.BAout     = r_ctrl.BAout;
    assign bus.ADD       = r_ctrl.ADD;
    assign bus.SUB       = r_ctrl.SUB;
    assign bus.AND       = r_ctrl.AND;
    assign bus.OR        = r_ctrl.OR;
    assign bus.SHR       = r_ctrl.SHR;
    assign bus.SHRA      = r_ctrl.SHRA;
    assign bus.SHL       = r_ctrl.SHL;
    assign bus.ROR       = r_ctrl.ROR;
    assign bus.ROL       = r_ctrl.ROL;
    assign bus.MUL       = r_ctrl.MUL;
    assign bus.DIV       = r_ctrl.DIV;
    assign bus.NEG       = r_ctrl.NEG;
    assign bus.NOT       = r_ctrl.NOT;

    // Not driven by this revision of the sequencer
    assign bus.RAMwrite  = 1'b0;
    assign bus.CONin     = 1'b0;
    assign bus.InPortout = 1'b0;
    assign bus.OutPortin = 1'b0;
    assign bus.HIout     = 1'b0;
    assign bus.LOout     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed self-checking bench for control_sequencer; compares
//               the full strobe vector every cycle against hand-built values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    typedef logic [42:0] vec_t;

    localparam vec_t M_RUN = vec_t'(1) << 42, M_PCOUT = vec_t'(1) << 41;
    localparam vec_t M_PCIN = vec_t'(1) << 40, M_INCPC = vec_t'(1) << 39;
    localparam vec_t M_MARIN = vec_t'(1) << 38, M_MDRIN = vec_t'(1) << 37;
    localparam vec_t M_MDROUT = vec_t'(1) << 36, M_MDMUX = vec_t'(1) << 35;
    localparam vec_t M_RAMRD = vec_t'(1) << 34, M_IRIN = vec_t'(1) << 33;
    localparam vec_t M_YIN = vec_t'(1) << 32, M_CSEOUT = vec_t'(1) << 31;
    localparam vec_t M_ZLIN = vec_t'(1) << 30, M_ZLOUT = vec_t'(1) << 29;
    localparam vec_t M_ZHIN = vec_t'(1) << 28, M_ZHOUT = vec_t'(1) << 27;
    localparam vec_t M_HIIN = vec_t'(1) << 26, M_LOIN = vec_t'(1) << 25;
    localparam vec_t M_GRA = vec_t'(1) << 24, M_GRB = vec_t'(1) << 23;
    localparam vec_t M_GRC = vec_t'(1) << 22, M_RIN = vec_t'(1) << 21;
    localparam vec_t M_ROUT = vec_t'(1) << 20, M_BAOUT = vec_t'(1) << 19;
    localparam vec_t M_ADD = vec_t'(1) << 18, M_SUB = vec_t'(1) << 17;
    localparam vec_t M_AND = vec_t'(1) << 16, M_OR = vec_t'(1) << 15;
    localparam vec_t M_SHR = vec_t'(1) << 14, M_SHRA = vec_t'(1) << 13;
    localparam vec_t M_SHL = vec_t'(1) << 12, M_ROR = vec_t'(1) << 11;
    localparam vec_t M_ROL = vec_t'(1) << 10, M_MUL = vec_t'(1) << 9;
    localparam vec_t M_DIV = vec_t'(1) << 8, M_NEG = vec_t'(1) << 7;
    localparam vec_t M_NOT = vec_t'(1) << 6;

    localparam vec_t E_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLIN;
    localparam vec_t E_T1 = M_RUN | M_ZLOUT | M_PCIN | M_MDMUX | M_RAMRD | M_MDRIN;
    localparam vec_t E_T2 = M_RUN | M_MDROUT | M_IRIN;
    localparam vec_t E_YB = M_RUN | M_GRB | M_ROUT | M_YIN;
    localparam vec_t E_WB = M_RUN | M_ZLOUT | M_GRA | M_RIN;
    localparam vec_t E_IMM4 = M_RUN | M_CSEOUT | M_ZLIN;
    localparam vec_t E_REG4 = M_RUN | M_GRC | M_ROUT | M_ZLIN;

    logic clock = 1'b0;
    logic clear;
    int   total = 0;
    int   bad   = 0;

    control_sequencer_if bus ();

    control_sequencer #(.OP_MSB(31), .OP_WIDTH(5)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    function automatic vec_t observe();
        return {bus.Run, bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin,
                bus.MDRout, bus.MDMuxread, bus.RAMread, bus.IRin, bus.Yin,
                bus.CSEout, bus.Zlowin, bus.Zlowout, bus.Zhighin, bus.Zhighout,
                bus.HIin, bus.LOin, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
                bus.BAout, bus.ADD, bus.SUB, bus.AND, bus.OR, bus.SHR, bus.SHRA,
                bus.SHL, bus.ROR, bus.ROL, bus.MUL, bus.DIV, bus.NEG, bus.NOT,
                bus.RAMwrite, bus.CONin, bus.InPortout, bus.OutPortin,
                bus.HIout, bus.LOout};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        vec_t obs;
        clear = 1'b1;
        bus.Stop = 1'b0;
        bus.IR = 32'h0A000050;
        for (int i = 0; i < 2; i++) begin
            tick();
            obs = observe();
            total++;
            if (obs !== vec_t'(0)) begin
                bad++;
                $display("FAIL reset cyc%0d: got %h want %h", i, obs, vec_t'(0));
            end
        end
        clear = 1'b0;
        tick();
        obs = observe();
        total++;
        if (obs !== E_T0) begin
            bad++;
            $display("FAIL reset_to_t0: got %h want %h", obs, E_T0);
        end
    endtask

    // Starts with T0 already showing; ends with the following T0 showing
    task automatic test_ldi_andi();
        vec_t obs;
        vec_t exp_q[$];
        bus.IR = 32'h0A000050;
        exp_q = '{E_T1, E_T2, M_RUN | M_GRB | M_BAOUT | M_YIN, E_IMM4 | M_ADD, E_WB, E_T0};
        foreach (exp_q[i]) begin
            tick();
            obs = observe();
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL ldi cyc%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
        bus.IR = 32'h69A00053;
        exp_q = '{E_T1, E_T2, E_YB, E_IMM4 | M_AND, E_WB, E_T0};
        foreach (exp_q[i]) begin
            tick();
            obs = observe();
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL andi cyc%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_alu_selects();
        vec_t obs;
        vec_t exp_q[$];
        logic [4:0] ops[9]  = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                5'b01000, 5'b01001, 5'b01010, 5'b01011};
        vec_t       sels[9] = '{M_ADD, M_SUB, M_AND, M_OR, M_ROR,
                                M_ROL, M_SHR, M_SHRA, M_SHL};
        for (int k = 0; k < 9; k++) begin
            bus.IR = {ops[k], 27'h0123456};
            exp_q = '{E_T1, E_T2, E_YB, E_REG4 | sels[k], E_WB, E_T0};
            foreach (exp_q[i]) begin
                tick();
                obs = observe();
                total++;
                if (obs !== exp_q[i]) begin
                    bad++;
                    $display("FAIL regop%0d cyc%0d: got %h want %h", k, i, obs, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_muldiv();
        vec_t obs;
        vec_t exp_q[$];
        logic [31:0] irs[2]  = '{32'h80000000, 32'h78000000};
        vec_t        sels[2] = '{M_MUL, M_DIV};
        for (int k = 0; k < 2; k++) begin
            bus.IR = irs[k];
            exp_q = '{E_T1, E_T2, M_RUN | M_GRA | M_ROUT | M_YIN,
                      M_RUN | M_GRB | M_ROUT | M_ZLIN | M_ZHIN | sels[k],
                      M_RUN | M_ZLOUT | M_LOIN, M_RUN | M_ZHOUT | M_HIIN, E_T0};
            foreach (exp_q[i]) begin
                tick();
                obs = observe();
                total++;
                if (obs !== exp_q[i]) begin
                    bad++;
                    $display("FAIL muldiv%0d cyc%0d: got %h want %h", k, i, obs, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_unary();
        vec_t obs;
        vec_t exp_q[$];
        logic [31:0] irs[2]  = '{32'h88000000, 32'h90000000};
        vec_t        sels[2] = '{M_NEG, M_NOT};
        for (int k = 0; k < 2; k++) begin
            bus.IR = irs[k];
            exp_q = '{E_T1, E_T2, M_RUN | M_GRB | M_ROUT | M_ZLIN | sels[k], E_WB, E_T0};
            foreach (exp_q[i]) begin
                tick();
                obs = observe();
                total++;
                if (obs !== exp_q[i]) begin
                    bad++;
                    $display("FAIL unary%0d cyc%0d: got %h want %h", k, i, obs, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_nop_undef();
        vec_t obs;
        vec_t exp_q[$];
        logic [31:0] irs[2] = '{32'hD0000000, 32'hF8000000};
        exp_q = '{E_T1, E_T2, E_T0};
        for (int k = 0; k < 2; k++) begin
            bus.IR = irs[k];
            foreach (exp_q[i]) begin
                tick();
                obs = observe();
                total++;
                if (obs !== exp_q[i]) begin
                    bad++;
                    $display("FAIL nop%0d cyc%0d: got %h want %h", k, i, obs, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stop();
        vec_t obs;
        vec_t exp_q[$];
        bus.IR = 32'h18000000;
        exp_q = '{E_T1, E_T2, E_YB, E_REG4 | M_ADD};
        foreach (exp_q[i]) begin
            tick();
            obs = observe();
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL stop_add cyc%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
        bus.Stop = 1'b1;
        tick();
        obs = observe();
        total++;
        if (obs !== E_WB) begin
            bad++;
            $display("FAIL stop_t5: got %h want %h", obs, E_WB);
        end
        for (int i = 0; i < 11; i++) begin
            if (i == 5) bus.Stop = 1'b0;
            tick();
            obs = observe();
            total++;
            if (obs !== vec_t'(0)) begin
                bad++;
                $display("FAIL halt_hold cyc%0d: got %h want %h", i, obs, vec_t'(0));
            end
        end
        clear = 1'b1;
        tick();
        obs = observe();
        total++;
        if (obs !== vec_t'(0)) begin
            bad++;
            $display("FAIL stop_clear: got %h want %h", obs, vec_t'(0));
        end
        clear = 1'b0;
        tick();
        obs = observe();
        total++;
        if (obs !== E_T0) begin
            bad++;
            $display("FAIL stop_restart: got %h want %h", obs, E_T0);
        end
    endtask

    task automatic test_clear_mid();
        vec_t obs;
        vec_t exp_q[$];
        bus.IR = 32'h69A00053;
        exp_q = '{E_T1, E_T2, E_YB, E_IMM4 | M_AND};
        foreach (exp_q[i]) begin
            tick();
            obs = observe();
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL clr_andi cyc%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
        clear = 1'b1;
        tick();
        obs = observe();
        total++;
        if (obs !== vec_t'(0)) begin
            bad++;
            $display("FAIL clr_mid: got %h want %h", obs, vec_t'(0));
        end
        clear = 1'b0;
        tick();
        obs = observe();
        total++;
        if (obs !== E_T0) begin
            bad++;
            $display("FAIL clr_restart: got %h want %h", obs, E_T0);
        end
    endtask

    task automatic test_halt();
        vec_t obs;
        vec_t exp_q[$];
        bus.IR = 32'hD8000000;
        exp_q = '{E_T1, E_T2, vec_t'(0), vec_t'(0), vec_t'(0)};
        foreach (exp_q[i]) begin
            tick();
            obs = observe();
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL halt_op cyc%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldi_andi();
        test_alu_selects();
        test_muldiv();
        test_unary();
        test_nop_undef();
        test_stop();
        test_clear_mid();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
